click_sink: RTL

CLICK_SINK -- requirements
Module: click_sink

---
 rtl/click_sink.sv | 97 +++++++++
 1 files changed

// File: rtl/click_sink.sv
// click_sink: clocked consumer endpoint of a 2-phase click FIFO, with a local token buffer.
// Optional consumed-token counter on o_tokens is built only when CLICK_SINK_STATS_EN is defined.
module click_sink #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_drive,
  output logic        o_free,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [3:0]  o_count,
  output logic        o_overflow,
  output logic [15:0] o_tokens
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   ack_pending_q;
  logic                   arrival;
  logic                   consume;
  logic [3:0]             count_d;
  logic                   pend_d;
  logic                   ovf_d;
  logic                   free_tgl;

  assign arrival = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign consume = o_valid & i_ready;

  // ack_pending implies o_count == DEPTH, so a serviced deferred ack never
  // coincides with an immediate ack on the same edge.
  always_comb begin
    count_d  = o_count;
    pend_d   = ack_pending_q;
    ovf_d    = o_overflow;
    free_tgl = 1'b0;
    if (arrival && !consume) begin
      if (o_count == DEPTH_C) begin
        ovf_d = 1'b1;
      end else begin
        count_d = o_count + 4'd1;
        if (count_d == DEPTH_C) pend_d = 1'b1;
        else                    free_tgl = 1'b1;
      end
    end else if (consume && !arrival) begin
      count_d = o_count - 4'd1;
      if (ack_pending_q) begin
        free_tgl = 1'b1;
        pend_d   = 1'b0;
      end
    end else if (arrival && consume) begin
      if (o_count == DEPTH_C) begin
        pend_d   = 1'b1;
        free_tgl = ack_pending_q;
      end else begin
        free_tgl = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      prev_q        <= 1'b0;
      ack_pending_q <= 1'b0;
      o_count       <= '0;
      o_valid       <= 1'b0;
      o_free        <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], i_drive};
      prev_q        <= sync_q[SYNC_STAGES-1];
      ack_pending_q <= pend_d;
      o_count       <= count_d;
      o_valid       <= (count_d != 4'd0);
      o_free        <= o_free ^ free_tgl;
      o_overflow    <= ovf_d;
    end
  end

`ifdef CLICK_SINK_STATS_EN
  logic [15:0] tokens_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tokens_q <= '0;
    else if (consume) tokens_q <= tokens_q + 16'd1;
  end

  assign o_tokens = tokens_q;
`else
  assign o_tokens = '0;
`endif

endmodule
